// File: rtl/ofs_fim_axi_mmio_csr_pkg.sv
// Shared types and AXI encodings for the AXI MMIO to CSR bridge.
// Imported by the bridge top and its timeout counter.
package ofs_fim_axi_mmio_csr_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_DATA,
      WR_CSR,
      WR_RESP,
      RD_CSR,
      RD_RESP
   } state_e;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

endpackage

// File: rtl/ofs_fim_axi_mmio_csr_timer.sv
// Per-beat CSR timeout counter: counts cycles while run is high.
// expired flags the last allowed cycle; TIMEOUT = 0 never expires.
module ofs_fim_axi_mmio_csr_timer
   import ofs_fim_axi_mmio_csr_pkg::*;
#(
   parameter int TIMEOUT = 512
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic run,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 2);
   localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      if (run && !clr) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   // cnt_q holds the number of completed request cycles before this one
   assign expired = (TIMEOUT != 0) && run && (cnt_q == LIMIT);

endmodule

// File: rtl/ofs_fim_axi_mmio_csr_bridge.sv
// AXI-4 MMIO slave that serializes every burst beat into one CSR request,
// one transaction at a time, with a per-beat CSR acknowledge timeout.
module ofs_fim_axi_mmio_csr_bridge
   import ofs_fim_axi_mmio_csr_pkg::*;
#(
   parameter int ID_WIDTH    = 10,
   parameter int ADDR_WIDTH  = 21,
   parameter int DATA_WIDTH  = 64,
   parameter int CSR_TIMEOUT = 512
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [ID_WIDTH-1:0]     awid,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [7:0]              awlen,
   input  logic [1:0]              awburst,
   input  logic [2:0]              awsize,
   input  logic                    awlock,
   input  logic [3:0]              awcache,
   input  logic [2:0]              awprot,
   input  logic [3:0]              awqos,
   input  logic                    awuser,
   input  logic                    wvalid,
   output logic                    wready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wlast,
   input  logic                    wuser,
   output logic                    bvalid,
   input  logic                    bready,
   output logic [ID_WIDTH-1:0]     bid,
   output logic [1:0]              bresp,
   output logic                    buser,
   input  logic                    arvalid,
   output logic                    arready,
   input  logic [ID_WIDTH-1:0]     arid,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic [7:0]              arlen,
   input  logic [1:0]              arburst,
   input  logic [2:0]              arsize,
   input  logic                    arlock,
   input  logic [3:0]              arcache,
   input  logic [2:0]              arprot,
   input  logic [3:0]              arqos,
   input  logic                    aruser,
   output logic                    rvalid,
   input  logic                    rready,
   output logic [ID_WIDTH-1:0]     rid,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    rlast,
   output logic                    ruser,
   output logic                    csr_req,
   output logic                    csr_write,
   output logic [ADDR_WIDTH-1:0]   csr_addr,
   output logic [DATA_WIDTH-1:0]   csr_wdata,
   output logic [DATA_WIDTH/8-1:0] csr_wstrb,
   input  logic                    csr_ack,
   input  logic [DATA_WIDTH-1:0]   csr_rdata,
   input  logic                    csr_err
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(STRB_W);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_W - 1);

   state_e                  state_q, state_d;
   logic                    last_wr_q, last_wr_d;
   logic [ID_WIDTH-1:0]     id_q, id_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [8:0]              beats_q, beats_d;
   logic [1:0]              burst_q, burst_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]       wstrb_q, wstrb_d;
   logic                    berr_q, berr_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;

   logic grant_wr, grant_rd, in_csr, tmo, beat_done, beat_err;
   logic unused_ok;

   // Ties go to whichever direction was not served last
   assign grant_wr  = awvalid && (!arvalid || !last_wr_q);
   assign grant_rd  = arvalid && !grant_wr;
   assign in_csr    = (state_q == WR_CSR) || (state_q == RD_CSR);
   assign beat_done = in_csr && (csr_ack || tmo);
   assign beat_err  = csr_ack ? csr_err : 1'b1;

   ofs_fim_axi_mmio_csr_timer #(
      .TIMEOUT (CSR_TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (beat_done),
      .run     (in_csr),
      .expired (tmo)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // beats_q is decremented as each beat completes, so 1 in WR_CSR means last
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_wr) state_d = WR_DATA;
                  else if (grant_rd) state_d = RD_CSR;
         WR_DATA: if (wvalid) state_d = WR_CSR;
         WR_CSR:  if (beat_done) state_d = (beats_q == 9'd1) ? WR_RESP : WR_DATA;
         WR_RESP: if (bready) state_d = IDLE;
         RD_CSR:  if (beat_done) state_d = RD_RESP;
         RD_RESP: if (rready) state_d = (beats_q == 9'd0) ? IDLE : RD_CSR;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      last_wr_d = last_wr_q;
      id_d      = id_q;
      addr_d    = addr_q;
      beats_d   = beats_q;
      burst_d   = burst_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      berr_d    = berr_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      if (state_q == IDLE) begin
         if (grant_wr) begin
            last_wr_d = 1'b1;
            id_d      = awid;
            addr_d    = awaddr & ALIGN_MASK;
            beats_d   = {1'b0, awlen} + 9'd1;
            burst_d   = awburst;
            berr_d    = 1'b0;
         end else if (grant_rd) begin
            last_wr_d = 1'b0;
            id_d      = arid;
            addr_d    = araddr & ALIGN_MASK;
            beats_d   = {1'b0, arlen} + 9'd1;
            burst_d   = arburst;
         end
      end
      if ((state_q == WR_DATA) && wvalid) begin
         wdata_d = wdata;
         wstrb_d = wstrb;
      end
      if (beat_done) begin
         beats_d = beats_q - 9'd1;
         if (burst_q != AXI_BURST_FIXED) addr_d = addr_q + STEP;
         if (state_q == WR_CSR) begin
            berr_d = berr_q | beat_err;
         end else begin
            rdata_d = csr_ack ? csr_rdata : '0;
            rresp_d = beat_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_wr_q <= 1'b0;
         id_q      <= '0;
         addr_q    <= '0;
         beats_q   <= '0;
         burst_q   <= AXI_BURST_FIXED;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         berr_q    <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= AXI_RESP_OKAY;
      end else begin
         last_wr_q <= last_wr_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         beats_q   <= beats_d;
         burst_q   <= burst_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         berr_q    <= berr_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   // Address readies are combinational on valid, so keep them quiet in reset
   assign awready   = rst_n && (state_q == IDLE) && grant_wr;
   assign arready   = rst_n && (state_q == IDLE) && grant_rd;
   assign wready    = (state_q == WR_DATA);
   assign bvalid    = (state_q == WR_RESP);
   assign bid       = id_q;
   assign bresp     = berr_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
   assign buser     = 1'b0;
   assign rvalid    = (state_q == RD_RESP);
   assign rid       = id_q;
   assign rdata     = rdata_q;
   assign rresp     = rresp_q;
   assign rlast     = (state_q == RD_RESP) && (beats_q == 9'd0);
   assign ruser     = 1'b0;
   assign csr_req   = in_csr;
   assign csr_write = (state_q == WR_CSR);
   assign csr_addr  = addr_q;
   assign csr_wdata = wdata_q;
   assign csr_wstrb = wstrb_q;

   assign unused_ok = ^{awsize, awlock, awcache, awprot, awqos, awuser, wuser, wlast,
                        arsize, arlock, arcache, arprot, arqos, aruser};

endmodule

// File: doc/ofs_fim_axi_mmio_csr_bridge.md
# ofs_fim_axi_mmio_csr_bridge

AXI-4 MMIO slave that terminates the FIM AXI MMIO interface and converts each burst beat into a single request on a simple CSR register port. Sits directly downstream of the AXI MMIO fabric, in front of the CSR register files. Handles one transaction at a time: reads and writes are serialized, single-beat or INCR/FIXED bursts, and there is a per-beat CSR timeout.

## Interface
- ID_WIDTH, 10, AXI awid/arid/bid/rid width
- ADDR_WIDTH, 21, AXI and CSR byte-address width
- DATA_WIDTH, 64, data width; wstrb = DATA_WIDTH/8
- CSR_TIMEOUT, 512, cycles to wait for csr_ack; 0 disables the timeout
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- awvalid/awready  in/out  1  write address handshake
- awid, awaddr, awlen, awburst  in  ID_WIDTH/ADDR_WIDTH/8/2  write address fields
- wvalid/wready  in/out  1  write data handshake
- wdata, wstrb, wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data fields
- bvalid/bready  out/in  1  write response handshake
- bid, bresp  out  ID_WIDTH/2  write response fields
- arvalid/arready  in/out  1  read address handshake
- arid, araddr, arlen, arburst  in  ID_WIDTH/ADDR_WIDTH/8/2  read address fields
- rvalid/rready  out/in  1  read data handshake
- rid, rdata, rresp, rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data fields
- awsize, awlock, awcache, awprot, awqos, awuser, wuser, arsize, arlock, arcache, arprot, arqos, aruser  in  per bus  accepted but ignored; buser and ruser are driven 0
- csr_req  out  1  CSR request, held until ack or timeout
- csr_write  out  1  1 = write, 0 = read
- csr_addr  out  ADDR_WIDTH  byte address, aligned down to DATA_WIDTH/8
- csr_wdata, csr_wstrb  out  DATA_WIDTH/DATA_WIDTH/8  write payload
- csr_ack  in  1  single-cycle completion pulse
- csr_rdata  in  DATA_WIDTH  read data, valid with csr_ack
- csr_err  in  1  error flag, valid with csr_ack

## Operation
- FSM states: IDLE, WR_DATA, WR_CSR, WR_RESP, RD_CSR, RD_RESP.
- IDLE arbitration. If only one of awvalid/arvalid is high, that direction is granted. If both are high, the direction not served last is granted. After reset, the write direction wins the first tie.
- awready = IDLE && grant_wr; arready = IDLE && grant_rd. On the handshake, the bridge latches id, the aligned address, the beat count (len+1), and the burst type.
- Write path:
  - WR_DATA: wready=1. On a W handshake, wdata/wstrb are captured, then go to WR_CSR.
  - WR_CSR: csr_req=1 and csr_write=1 until ack or timeout.
  - After the beat completes: if it was the last beat, go to WR_RESP; otherwise go back to WR_DATA.
  - The W beat whose count reaches len+1 is the last beat; wlast itself is ignored.
- Read path:
  - RD_CSR: issues the request.
  - On ack, rdata is captured and the FSM goes to RD_RESP. rvalid=1 until rready; rlast=1 on the final beat.
  - After the handshake: if beats remain, go to RD_CSR; otherwise go to IDLE.
- Address step: INCR and WRAP advance by DATA_WIDTH/8 (WRAP is treated as INCR). FIXED holds the address. The address wraps modulo 2^ADDR_WIDTH.
- Response code, OKAY=2'b00, SLVERR=2'b10:
  - A read beat's rresp is SLVERR if that beat had csr_err or timed out.
  - bresp is SLVERR if any beat of the burst had an error.
- Timeout: a counter runs while csr_req=1. Reaching CSR_TIMEOUT drops csr_req and completes the beat as an error; for reads, rdata=0. A csr_ack arriving in the same cycle as the timeout wins.
- A csr_ack seen outside RD_CSR/WR_CSR is ignored.

## Timing
- Reset state: FSM=IDLE and all counters 0.
- Outputs during reset: awready, arready, wready, bvalid, rvalid, rlast, csr_req are 0. bid, rid, bresp, rresp, rdata, csr_* are also 0.
- Reset applied mid-transaction aborts it: nothing is completed and there is no response.
- Single-beat read: AR handshake at cycle T; csr_req from T+1; csr_ack at T+1+k (k≥0); rvalid at T+2+k.
- Single-beat write: AW at T; wready from T+1. W handshake at W; csr_req from W+1; ack at W+1+k; bvalid at W+2+k.
- CSR outputs are registered and stable while csr_req=1. bvalid and rvalid hold until their ready is seen.
- Timeout: csr_req is low in the cycle after count = CSR_TIMEOUT.
- Read throughput for a burst: one beat per (2 + k) cycles with rready held high.

## Structure
- Package ofs_fim_axi_mmio_csr_pkg holds:
  - the state enum;
  - AXI_RESP_OKAY and AXI_RESP_SLVERR;
  - AXI_BURST_FIXED, AXI_BURST_INCR and AXI_BURST_WRAP.
- One sub-module, ofs_fim_axi_mmio_csr_timer: a loadable timeout counter with inputs clr/run and output expired.

## Test plan
- Single read: araddr=0x100, arid=5, csr_rdata=0xDEAD_BEEF at ack k=3 -> csr_addr=0x100; rvalid 5 cycles after AR handshake with rid=5, rdata=0xDEADBEEF, rresp=0, rlast=1.
- INCR write burst: awaddr=0x40, awlen=3, four W beats -> csr_addr 0x40,0x48,0x50,0x58 in order; a single response bresp=OKAY, bid matching awid.
- FIXED read burst: arlen=1, arburst=0 -> two CSR reads at the same address; rlast only on the second beat.
- Error and timeout:
  - Write burst of 2 with csr_err on beat 1 -> bresp=SLVERR.
  - Read with no ack, CSR_TIMEOUT=16 -> csr_req drops after 16 cycles; rresp=SLVERR, rdata=0.
- Arbitration: awvalid and arvalid high together after reset -> write first, then read; repeated ties alternate.
- Backpressure and reset:
  - rready held low for 10 cycles -> rvalid/rdata stable throughout, no new csr_req.
  - rst_n low during RD_CSR -> all outputs 0 the next cycle; the FSM accepts a new AR afterwards.
